// File: rtl/vx_icache_stage_if.sv
// Fetch-stage bus bundle: scheduler requests, icache request/response and the decode response.
// The master modport is the fetch stage; the slave modport is its environment.
interface vx_icache_stage_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4
);
  localparam int unsigned NW_BITS = $clog2(NUM_WARPS);

  logic                   ifetch_req_valid;
  logic [NW_BITS-1:0]     ifetch_req_wid;
  logic [NUM_THREADS-1:0] ifetch_req_tmask;
  logic [31:0]            ifetch_req_PC;
  logic                   ifetch_req_ready;

  logic                   icache_req_valid;
  logic [29:0]            icache_req_addr;
  logic [NW_BITS-1:0]     icache_req_tag;
  logic                   icache_req_ready;

  logic                   icache_rsp_valid;
  logic [31:0]            icache_rsp_data;
  logic [NW_BITS-1:0]     icache_rsp_tag;
  logic                   icache_rsp_ready;

  logic                   ifetch_rsp_valid;
  logic [NW_BITS-1:0]     ifetch_rsp_wid;
  logic [NUM_THREADS-1:0] ifetch_rsp_tmask;
  logic [31:0]            ifetch_rsp_PC;
  logic [31:0]            ifetch_rsp_instr;
  logic                   ifetch_rsp_ready;

  modport master (
    input  ifetch_req_valid, ifetch_req_wid, ifetch_req_tmask, ifetch_req_PC,
    output ifetch_req_ready,
    output icache_req_valid, icache_req_addr, icache_req_tag,
    input  icache_req_ready,
    input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    output icache_rsp_ready,
    output ifetch_rsp_valid, ifetch_rsp_wid, ifetch_rsp_tmask, ifetch_rsp_PC, ifetch_rsp_instr,
    input  ifetch_rsp_ready
  );

  modport slave (
    output ifetch_req_valid, ifetch_req_wid, ifetch_req_tmask, ifetch_req_PC,
    input  ifetch_req_ready,
    input  icache_req_valid, icache_req_addr, icache_req_tag,
    output icache_req_ready,
    output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    input  icache_rsp_ready,
    input  ifetch_rsp_valid, ifetch_rsp_wid, ifetch_rsp_tmask, ifetch_rsp_PC, ifetch_rsp_instr,
    output ifetch_rsp_ready
  );
endinterface

// File: rtl/vx_icache_stage.sv
// Instruction-fetch stage: forwards warp fetches to the icache tagged by warp id, keeps per-warp
// metadata, and rejoins it with the returned word in a single registered response to decode.
module vx_icache_stage #(
  parameter int unsigned CORE_ID     = 0,
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_icache_stage_if.master    bus,
  output logic [NUM_WARPS-1:0] pending_warps,
  output logic                 busy,
  output logic                 proto_err
);
  localparam int unsigned NW_BITS = $clog2(NUM_WARPS);

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
  } meta_t;

  typedef struct packed {
    logic               valid;
    logic [NW_BITS-1:0] wid;
    meta_t              meta;
    logic [31:0]        instr;
  } rsp_t;

  meta_t                meta_q [NUM_WARPS];
  logic [NUM_WARPS-1:0] pending_q, pending_d;
  rsp_t                 rsp_q, rsp_d;
  logic                 proto_err_q, proto_err_d;

  logic               req_fire, rsp_fire, rsp_ready;
  logic               req_err, rsp_err;
  logic [NW_BITS-1:0] req_wid, rsp_tag;

  assign req_wid = bus.ifetch_req_wid;
  assign rsp_tag = bus.icache_rsp_tag;

  // Request path is a pure pass-through; the cache's ready is the scheduler's ready.
  assign bus.icache_req_valid = bus.ifetch_req_valid;
  assign bus.ifetch_req_ready = bus.icache_req_ready;
  assign bus.icache_req_addr  = bus.ifetch_req_PC[31:2];
  assign bus.icache_req_tag   = req_wid;

  assign rsp_ready            = !rsp_q.valid || bus.ifetch_rsp_ready;
  assign bus.icache_rsp_ready = rsp_ready;

  assign req_fire = bus.ifetch_req_valid && bus.icache_req_ready;
  assign rsp_fire = bus.icache_rsp_valid && rsp_ready;

  // A re-request is legal only when the same warp's response retires in this cycle.
  assign req_err = req_fire && pending_q[req_wid] && !(rsp_fire && (rsp_tag == req_wid));
  assign rsp_err = rsp_fire && !pending_q[rsp_tag];

  always_comb begin
    pending_d = pending_q;
    if (rsp_fire) pending_d[rsp_tag] = 1'b0;
    if (req_fire) pending_d[req_wid] = 1'b1;
  end

  always_comb begin
    rsp_d = rsp_q;
    if (rsp_fire) begin
      rsp_d.valid = 1'b1;
      rsp_d.wid   = rsp_tag;
      rsp_d.meta  = meta_q[rsp_tag];
      rsp_d.instr = bus.icache_rsp_data;
    end else if (bus.ifetch_rsp_ready) begin
      rsp_d.valid = 1'b0;
    end
  end

  assign proto_err_d = proto_err_q || req_err || rsp_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      rsp_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      rsp_q       <= rsp_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Metadata needs no reset: an entry is only read after its warp's request wrote it.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      meta_q[req_wid] <= '{tmask: bus.ifetch_req_tmask, pc: bus.ifetch_req_PC};
    end
  end

  assign bus.ifetch_rsp_valid = rsp_q.valid;
  assign bus.ifetch_rsp_wid   = rsp_q.wid;
  assign bus.ifetch_rsp_tmask = rsp_q.meta.tmask;
  assign bus.ifetch_rsp_PC    = rsp_q.meta.pc;
  assign bus.ifetch_rsp_instr = rsp_q.instr;

  assign pending_warps = pending_q;
  assign busy          = (|pending_q) || rsp_q.valid;
  assign proto_err     = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset && req_err) begin
      $warning("vx_icache_stage core %0d: fetch for warp %0d already outstanding", CORE_ID,
               req_wid);
    end
    if (reset && rsp_err) begin
      $warning("vx_icache_stage core %0d: icache response for idle warp %0d", CORE_ID, rsp_tag);
    end
  end
endmodule
